cic_decimator: RTL and testbench
================================

CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 SHALL have parameter DATA_IN_WIDTH, default 12, meaning signed input sample width.
REQ-002 SHALL have parameter STAGES, default 3, meaning the number of integrator stages and the number of comb stages (N), legal range 1..6.
REQ-003 SHALL have parameter DECIMATION, default 8, meaning the rate-change factor R, a power of two in the range 2..256.
REQ-004 SHALL derive localparam DATA_OUT_WIDTH = DATA_IN_WIDTH + STAGES*log2(DECIMATION), meaning the full-precision output width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port s_axis_tdata, input, DATA_IN_WIDTH bits: signed input sample.
REQ-008 SHALL have port s_axis_tvalid, input, 1 bit: input sample valid.
REQ-009 SHALL have port s_axis_tready, output, 1 bit: tied high, so every valid sample is accepted.
REQ-010 SHALL have port m_axis_tdata, output, DATA_OUT_WIDTH bits: signed decimated output.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: output valid.
REQ-012 SHALL have port m_axis_tready, input, 1 bit: downstream accept.

Function
REQ-013 SHALL sign-extend the input to DATA_OUT_WIDTH; all integrator and comb arithmetic SHALL be two's complement modulo 2^DATA_OUT_WIDTH, with wrap intentional and no saturation.
REQ-014 SHALL update the integrators only on a cycle where s_axis_tvalid=1: I1 <= I1 + x and Ik <= Ik + I(k-1) using pre-edge values. Integrators SHALL hold while tvalid=0.
REQ-015 SHALL keep a phase counter, 0..R-1, that increments per accepted sample and wraps from R-1 to 0.
REQ-016 SHALL generate a decimation strobe on the accepted sample where the counter equals R-1; on that edge it SHALL capture the pre-edge IN value into the comb pipeline.
REQ-017 SHALL implement each comb stage k (differential delay 1) as a register advanced once per strobe-propagated valid: Ck <= C(k-1) - Dk, Dk <= C(k-1).
REQ-018 SHALL assert m_axis_tvalid exactly STAGES+1 clocks after the strobe edge, when the output register is free.
REQ-019 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 SHALL consume the output on an edge where m_axis_tvalid=1 and m_axis_tready=1, clearing tvalid unless a new result loads on the same edge, in which case tvalid SHALL stay 1 with new data.
REQ-021 SHALL overwrite the held output with the new result when a new result arrives while tvalid=1 and tready=0; the older result is lost.
REQ-022 SHALL tolerate s_axis_tvalid gaps of any length with no change to results versus gap-free input.

Reset
REQ-023 SHALL, while reset_n=0 at a rising edge, clear all integrators, comb and delay registers, the phase counter, and the pipeline valid bits, and set m_axis_tvalid=0 and m_axis_tdata=0.
REQ-024 SHALL discard any in-flight comb result when reset is applied mid-operation; after release the first output follows R accepted samples.

Configuration
REQ-025 SHALL, when macro CIC_OVERRUN_DETECT_EN is defined, add output port overrun (1 bit). overrun SHALL be sticky high from the edge an overwrite per REQ-021 occurs, and cleared only by reset.
REQ-026 SHALL, when CIC_OVERRUN_DETECT_EN is undefined, omit the overrun port and its logic, with all other behaviour identical.

Verification
REQ-027 SHALL cover DC positive: STAGES=3, R=8, tready=1, constant input 1 every cycle -> outputs every 8 cycles, from the 4th output onward m_axis_tdata=512.
REQ-028 SHALL cover DC full-scale negative: constant -2048 -> steady output -1048576 (21-bit minimum), with no spurious wrap.
REQ-029 SHALL cover a valid gap pattern: constant 1 with tvalid toggling 1,0 -> identical output values, spaced 16 cycles apart.
REQ-030 SHALL cover backpressure: tready=0 for 20 cycles during DC 1 -> tdata held stable and newest value kept, overrun=1 when CIC_OVERRUN_DETECT_EN is defined; after tready=1, the stream resumes at 512.
REQ-031 SHALL cover reset mid-operation: reset_n=0 for 1 cycle after 5 samples -> m_axis_tvalid=0 and all state zero; the next output appears STAGES+1 cycles after the 8th post-reset sample.

Source files
------------

// File: rtl/cic_decimator.sv
// cic_decimator: N-stage, rate-R CIC decimation filter with an AXI-Stream style
// input (always ready) and a single-entry output register.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   s_axis_tdata   signed input sample, DATA_IN_WIDTH bits
//   s_axis_tvalid  input sample valid
//   s_axis_tready  constant 1, every valid sample is accepted
//   m_axis_tdata   signed decimated output, DATA_OUT_WIDTH bits
//   m_axis_tvalid  output valid
//   m_axis_tready  downstream accept
//   overrun        (only with CIC_OVERRUN_DETECT_EN) sticky flag, set when an
//                  unconsumed output is overwritten by a newer result
//
// Optional feature macro: CIC_OVERRUN_DETECT_EN
//
// All arithmetic is full-precision two's complement modulo 2^DATA_OUT_WIDTH;
// integrator wrap is intentional and cancelled by the comb section.

module cic_decimator #(
    parameter int unsigned DATA_IN_WIDTH  = 12,
    parameter int unsigned STAGES         = 3,
    parameter int unsigned DECIMATION     = 8,
    localparam int unsigned DATA_OUT_WIDTH = DATA_IN_WIDTH + STAGES * $clog2(DECIMATION)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_OUT_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
`ifdef CIC_OVERRUN_DETECT_EN
    ,
    output logic                      overrun
`endif
);

    localparam int unsigned PHASE_WIDTH = $clog2(DECIMATION);
    localparam int unsigned EXT_WIDTH   = DATA_OUT_WIDTH - DATA_IN_WIDTH;

    logic [DATA_OUT_WIDTH-1:0] integ [STAGES];
    logic [DATA_OUT_WIDTH-1:0] comb  [STAGES];
    logic [DATA_OUT_WIDTH-1:0] dly   [STAGES];
    logic [DATA_OUT_WIDTH-1:0] comb_in;
    logic [STAGES:0]           vld;
    logic [PHASE_WIDTH-1:0]    phase;

    logic [DATA_OUT_WIDTH-1:0] x_ext;
    logic                      strobe;

    assign s_axis_tready = 1'b1;

    // Sign-extend the input sample to the full accumulator width.
    assign x_ext = {{EXT_WIDTH{s_axis_tdata[DATA_IN_WIDTH-1]}}, s_axis_tdata};

    // Decimation strobe: the accepted sample that completes a block of R.
    assign strobe = s_axis_tvalid && (phase == PHASE_WIDTH'(DECIMATION - 1));

    // Integrators, phase counter, comb pipeline and output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                integ[k] <= '0;
                comb[k]  <= '0;
                dly[k]   <= '0;
            end
            comb_in       <= '0;
            vld           <= '0;
            phase         <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
`ifdef CIC_OVERRUN_DETECT_EN
            overrun       <= 1'b0;
`endif
        end else begin
            // Integrators advance only on accepted samples, each using the
            // pre-edge value of the stage before it.
            if (s_axis_tvalid) begin
                integ[0] <= integ[0] + x_ext;
                for (int k = 1; k < int'(STAGES); k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                // R is a power of two, so the counter wraps naturally.
                phase <= phase + PHASE_WIDTH'(1);
            end

            // Decimated sample enters the comb section.
            if (strobe) begin
                comb_in <= integ[STAGES-1];
            end
            vld <= {vld[STAGES-1:0], strobe};

            // Comb stages, differential delay 1, each advanced by its input valid.
            if (vld[0]) begin
                comb[0] <= comb_in - dly[0];
                dly[0]  <= comb_in;
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (vld[k]) begin
                    comb[k] <= comb[k-1] - dly[k];
                    dly[k]  <= comb[k-1];
                end
            end

            // Output register: a new result always loads, overwriting any
            // result the downstream has not yet taken.
            if (vld[STAGES]) begin
                m_axis_tdata  <= comb[STAGES-1];
                m_axis_tvalid <= 1'b1;
`ifdef CIC_OVERRUN_DETECT_EN
                if (m_axis_tvalid && !m_axis_tready) begin
                    overrun <= 1'b1;
                end
`endif
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: self-checking bench for cic_decimator (default parameters).
// The reference model keeps the accepted samples since reset, computes the
// last integrator's value at each decimation point from its closed form
// (binomial-weighted sum of inputs), takes the N-th difference of that
// decimated sequence, and schedules each result STAGES+1 cycles after its
// strobe into a behavioural single-entry output register.

module tb_cic_decimator;

    localparam int unsigned DIW  = 12;
    localparam int unsigned N    = 3;
    localparam int unsigned R    = 8;
    localparam int unsigned W    = DIW + N * 3;
    localparam longint      MASK = (longint'(1) <<< W) - 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [DIW-1:0] s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
`ifdef CIC_OVERRUN_DETECT_EN
    logic           overrun;
`endif

    cic_decimator #(
        .DATA_IN_WIDTH (DIW),
        .STAGES        (N),
        .DECIMATION    (R)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef CIC_OVERRUN_DETECT_EN
        ,
        .overrun       (overrun)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct {
        int     due;
        longint val;
    } pend_t;

    longint xs[$];
    longint ys[$];
    pend_t  pend[$];
    bit     mv;
    longint md;
    bit     movr;
    int     cyc = 0;

    // Observation helpers for directed checks
    logic [63:0] last_out;
    int          t_last;
    int          t_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic longint choose(input longint a, input int k);
        longint r;
        if (a < longint'(k)) return 0;
        r = 1;
        for (int t = 0; t < k; t++) r = r * (a - longint'(t)) / longint'(t + 1);
        return r;
    endfunction

    // Last integrator after n accepted samples: sum x[i] * C(n-1-i, N-1).
    function automatic longint integ_after(input int n);
        longint acc = 0;
        for (int i = 0; i < n; i++) begin
            acc = (acc + xs[i] * choose(longint'(n - 1 - i), N - 1)) & MASK;
        end
        return acc;
    endfunction

    // N-th difference of the decimated sequence, zero before the first term.
    function automatic longint comb_result();
        longint acc = 0;
        int     j   = ys.size();
        for (int m = 0; m <= int'(N); m++) begin
            if (j - 1 - m >= 0) begin
                if (m % 2 == 0) acc = acc + choose(longint'(N), m) * ys[j-1-m];
                else            acc = acc - choose(longint'(N), m) * ys[j-1-m];
            end
        end
        return acc & MASK;
    endfunction

    task automatic model_edge(input bit rn, input bit v, input logic [DIW-1:0] d, input bit rdy);
        int n;
        cyc++;
        if (!rn) begin
            xs.delete();
            ys.delete();
            pend.delete();
            mv   = 1'b0;
            md   = 0;
            movr = 1'b0;
            return;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (mv && !rdy) movr = 1'b1;
            md = pend[0].val;
            mv = 1'b1;
            void'(pend.pop_front());
        end else if (mv && rdy) begin
            mv = 1'b0;
        end
        if (v) begin
            n = xs.size();
            if (n % int'(R) == int'(R) - 1) begin
                ys.push_back(integ_after(n));
                pend.push_back('{cyc + int'(N) + 1, comb_result()});
            end
            xs.push_back(longint'($signed(d)));
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 unit later.
    task automatic step(input bit rn, input bit v, input logic [DIW-1:0] d, input bit rdy);
        reset_n       = rn;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        @(posedge clk);
        model_edge(rn, v, d, rdy);
        #1;
        check("s_tready", 64'(s_axis_tready), 64'(1));
        check("m_tvalid", 64'(m_axis_tvalid), 64'(mv));
        check("m_tdata", 64'(m_axis_tdata), 64'(md & MASK));
`ifdef CIC_OVERRUN_DETECT_EN
        check("overrun", 64'(overrun), 64'(movr));
`endif
        if (m_axis_tvalid) begin
            last_out = 64'(m_axis_tdata);
            t_prev   = t_last;
            t_last   = cyc;
        end
    endtask

    initial begin
        int lat;
        bit rn;
        bit v;
        bit rdy;
        logic [DIW-1:0] d;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        check("rst_init_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_init_tdata", 64'(m_axis_tdata), 64'(0));

        // DC +1, gap-free, no backpressure
        last_out = '0;
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1, DIW'(1), 1'b1);
        check("dc_pos", last_out, 64'(512));

        // DC full-scale negative
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        last_out = '0;
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1, DIW'(12'h800), 1'b1);
        check("dc_neg", last_out, 64'((-1048576) & MASK));

        // DC +1 with valid toggling 1,0
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        last_out = '0;
        for (int i = 0; i < 320; i++) step(1'b1, (i % 2) == 0, DIW'(1), 1'b1);
        check("gap_val", last_out, 64'(512));
        check("gap_space", 64'(t_last - t_prev), 64'(16));

        // Backpressure for 20 cycles, then resume
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DIW'(1), 1'b0);
        check("bp_held_valid", 64'(m_axis_tvalid), 64'(1));
        check("bp_held_data", 64'(m_axis_tdata), 64'(512));
`ifdef CIC_OVERRUN_DETECT_EN
        check("bp_overrun", 64'(overrun), 64'(1));
`endif
        last_out = '0;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DIW'(1), 1'b1);
        check("bp_resume", last_out, 64'(512));

        // Reset after 5 samples, then latency of the first post-reset output
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DIW'($urandom), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_mid_tdata", 64'(m_axis_tdata), 64'(0));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, DIW'($urandom), 1'b1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (m_axis_tvalid) begin
                lat = k;
                break;
            end
        end
        check("rst_latency", 64'(lat), 64'(N + 1));

        // Randomised traffic: data, valid gaps, backpressure, rare resets
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            rn  = ($urandom_range(0, 499) != 0);
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 9))
                0:       d = DIW'(12'h800);
                1:       d = DIW'(12'h7ff);
                default: d = DIW'($urandom);
            endcase
            step(rn, v, d, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
